// File: rtl/rx_serdes_pkg.sv
// Shared constants and link-state encoding for the 8b/10b receive alignment path.
// Optional VERIFY timeout in rx_link_sync_ctrl is enabled by RX_ALIGN_TIMEOUT_EN.
package rx_serdes_pkg;

    localparam logic [9:0] COMMA_NEG = 10'b1100000101;
    localparam logic [9:0] COMMA_POS = 10'b0011111010;
    localparam int         SYM_BITS  = 10;
    localparam int         PHASE_W   = $clog2(SYM_BITS);

    typedef enum logic [1:0] {
        LINK_HUNT   = 2'd0,
        LINK_VERIFY = 2'd1,
        LINK_SYNC   = 2'd2
    } link_state_t;

endpackage

// File: rtl/rx_phase_counter.sv
// Mod-10 bit-phase counter; boundary marks the cycle a full symbol sits in the window.
// Also reports whether the next cycle is a boundary, so callers can register strobes.
module rx_phase_counter
    import rx_serdes_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic align,
    output logic boundary,
    output logic boundary_next
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // The match cycle is itself phase 0, so the count resumes at 1 and the
    // next boundary lands exactly one symbol later.
    always_comb begin
        if (clear) begin
            phase_d = '0;
        end else if (align) begin
            phase_d = PHASE_W'(1);
        end else if (phase_q == PHASE_W'(SYM_BITS - 1)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign boundary      = (phase_q == '0);
    assign boundary_next = (phase_d == '0);

endmodule

// File: rtl/rx_link_sync_ctrl.sv
// K28.5 word-alignment and link-sync controller (HUNT / VERIFY / SYNC) for the 8b/10b RX path.
// Define RX_ALIGN_TIMEOUT_EN to drop back to HUNT when VERIFY sees no on-phase comma for too long.
module rx_link_sync_ctrl
    import rx_serdes_pkg::*;
#(
    parameter int VERIFY_COMMAS  = 3,
    parameter int LOSS_ERRS      = 4,
`ifdef RX_ALIGN_TIMEOUT_EN
    parameter int VERIFY_TIMEOUT = 64,
`endif
    parameter int GOOD_RUN       = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable,
    input  logic        clr_cnt,
    input  logic [9:0]  data_win,
    input  logic        code_err,
    input  logic        rd_err,
    output logic        sym_tick,
    output logic        sync_ok,
    output logic [1:0]  link_state,
    output logic        rd_load,
    output logic        rd_value,
    output logic [15:0] err_cnt,
    output logic [7:0]  relock_cnt
);

    localparam int VC_W  = $clog2(VERIFY_COMMAS + 1);
    localparam int BAD_W = $clog2(LOSS_ERRS + 1);
    localparam int GR_W  = $clog2(GOOD_RUN + 1);
`ifdef RX_ALIGN_TIMEOUT_EN
    localparam int TMR_W = $clog2(VERIFY_TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    link_state_t      state_q, state_d;
    logic [VC_W-1:0]  vcount_q, vcount_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic [GR_W-1:0]  good_q, good_d;
    logic             realign, sym_err, relock;
    logic             boundary, boundary_next;
    logic             is_pos, comma, err_flag;
    logic             sym_tick_d, sync_ok_d, rd_load_d, rd_value_d;

    assign is_pos   = (data_win == COMMA_POS);
    assign comma    = (data_win == COMMA_NEG) || is_pos;
    assign err_flag = code_err | rd_err;

    rx_phase_counter u_phase (
        .clk           (clk),
        .resetN        (resetN),
        .clear         (~enable),
        .align         (realign),
        .boundary      (boundary),
        .boundary_next (boundary_next)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= LINK_HUNT;
            vcount_q <= '0;
            bad_q    <= '0;
            good_q   <= '0;
`ifdef RX_ALIGN_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vcount_q <= vcount_d;
            bad_q    <= bad_d;
            good_q   <= good_d;
`ifdef RX_ALIGN_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        vcount_d = vcount_q;
        bad_d    = bad_q;
        good_d   = good_q;
        realign  = 1'b0;
        sym_err  = 1'b0;
        relock   = 1'b0;
`ifdef RX_ALIGN_TIMEOUT_EN
        timer_d  = timer_q;
`endif
        if (!enable) begin
            state_d  = LINK_HUNT;
            vcount_d = '0;
            bad_d    = '0;
            good_d   = '0;
        end else begin
            unique case (state_q)
                LINK_HUNT: begin
                    if (comma) begin
                        state_d  = LINK_VERIFY;
                        vcount_d = VC_W'(1);
                        realign  = 1'b1;
`ifdef RX_ALIGN_TIMEOUT_EN
                        timer_d  = '0;
`endif
                    end
                end
                LINK_VERIFY: begin
                    if (boundary) begin
                        if (err_flag) begin
                            state_d = LINK_HUNT;
                        end else if (comma) begin
                            vcount_d = vcount_q + 1'b1;
`ifdef RX_ALIGN_TIMEOUT_EN
                            timer_d  = '0;
`endif
                            if (vcount_q == VC_W'(VERIFY_COMMAS - 1)) begin
                                state_d = LINK_SYNC;
                            end
                        end else begin
`ifdef RX_ALIGN_TIMEOUT_EN
                            if (timer_q == TMR_W'(VERIFY_TIMEOUT - 1)) begin
                                state_d = LINK_HUNT;
                            end else begin
                                timer_d = timer_q + 1'b1;
                            end
`endif
                        end
                    end else if (comma) begin
                        // Off-phase comma: restart verification at the new alignment.
                        vcount_d = VC_W'(1);
                        realign  = 1'b1;
`ifdef RX_ALIGN_TIMEOUT_EN
                        timer_d  = '0;
`endif
                    end
                end
                LINK_SYNC: begin
                    if (boundary) begin
                        if (err_flag) begin
                            sym_err = 1'b1;
                            good_d  = '0;
                            if (bad_q == BAD_W'(LOSS_ERRS - 1)) begin
                                state_d = LINK_HUNT;
                                relock  = 1'b1;
                                bad_d   = '0;
                            end else begin
                                bad_d = bad_q + 1'b1;
                            end
                        end else if (good_q == GR_W'(GOOD_RUN - 1)) begin
                            // A full clean run forgives one counted error.
                            good_d = '0;
                            if (bad_q != '0) begin
                                bad_d = bad_q - 1'b1;
                            end
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                end
                default: state_d = LINK_HUNT;
            endcase
        end
    end

    always_comb begin
        sync_ok_d  = (state_d == LINK_SYNC);
        sym_tick_d = sync_ok_d && boundary_next;
        rd_load_d  = realign;
        rd_value_d = realign ? is_pos : rd_value;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sym_tick <= 1'b0;
            sync_ok  <= 1'b0;
            rd_load  <= 1'b0;
            rd_value <= 1'b0;
        end else begin
            sym_tick <= sym_tick_d;
            sync_ok  <= sync_ok_d;
            rd_load  <= rd_load_d;
            rd_value <= rd_value_d;
        end
    end

    // A clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            err_cnt    <= '0;
            relock_cnt <= '0;
        end else begin
            if (clr_cnt) begin
                err_cnt <= '0;
            end else if (sym_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (clr_cnt) begin
                relock_cnt <= '0;
            end else if (relock && (relock_cnt != '1)) begin
                relock_cnt <= relock_cnt + 1'b1;
            end
        end
    end

    assign link_state = state_q;

endmodule

// File: tb/tb_rx_link_sync_ctrl.sv
// Self-checking bench for rx_link_sync_ctrl: directed scenarios plus randomized symbol streams
// compared every cycle against a cycle-count based model; honours RX_ALIGN_TIMEOUT_EN.
module tb_rx_link_sync_ctrl;

    localparam logic [9:0] K_NEG = 10'b1100000101;
    localparam logic [9:0] K_POS = 10'b0011111010;

    logic        clk = 1'b0;
    logic        resetN, enable, clr_cnt, code_err, rd_err;
    logic [9:0]  data_win;
    logic        sym_tick, sync_ok, rd_load, rd_value;
    logic [1:0]  link_state;
    logic [15:0] err_cnt;
    logic [7:0]  relock_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: state 0/1/2, alignment remembered as the cycle index of the aligning comma.
    int m_state = 0, m_align = 0, m_vcount = 0, m_bad = 0, m_good = 0, m_timer = 0;
    int m_err = 0, m_relock = 0;
    bit m_rdl = 1'b0, m_rdv = 1'b0;

    always #5 clk = ~clk;

    rx_link_sync_ctrl dut (
        .clk        (clk),
        .resetN     (resetN),
        .enable     (enable),
        .clr_cnt    (clr_cnt),
        .data_win   (data_win),
        .code_err   (code_err),
        .rd_err     (rd_err),
        .sym_tick   (sym_tick),
        .sync_ok    (sync_ok),
        .link_state (link_state),
        .rd_load    (rd_load),
        .rd_value   (rd_value),
        .err_cnt    (err_cnt),
        .relock_cnt (relock_cnt)
    );

    function automatic logic [9:0] rand_word();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (w == K_NEG || w == K_POS);
        return w;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        bit bnd, cm, er, pos;
        pos   = (data_win == K_POS);
        cm    = pos || (data_win == K_NEG);
        er    = code_err || rd_err;
        bnd   = (m_state != 0) && (((cyc - m_align) % 10) == 0);
        m_rdl = 1'b0;
        if (!resetN) begin
            m_state = 0; m_vcount = 0; m_bad = 0; m_good = 0; m_timer = 0;
            m_err = 0; m_relock = 0; m_rdv = 1'b0;
        end else begin
            if (!enable) begin
                m_state = 0; m_bad = 0; m_good = 0;
            end else if (m_state == 0) begin
                if (cm) begin
                    m_state = 1; m_align = cyc; m_vcount = 1; m_timer = 0;
                    m_rdl = 1'b1; m_rdv = pos;
                end
            end else if (m_state == 1) begin
                if (bnd) begin
                    if (er) m_state = 0;
                    else if (cm) begin
                        m_vcount++; m_timer = 0;
                        if (m_vcount == 3) m_state = 2;
                    end else begin
                        m_timer++;
`ifdef RX_ALIGN_TIMEOUT_EN
                        if (m_timer == 64) m_state = 0;
`endif
                    end
                end else if (cm) begin
                    m_align = cyc; m_vcount = 1; m_timer = 0; m_rdl = 1'b1; m_rdv = pos;
                end
            end else if (bnd) begin
                if (er) begin
                    if (m_err < 65535) m_err++;
                    m_bad++; m_good = 0;
                    if (m_bad == 4) begin
                        m_state = 0; m_bad = 0;
                        if (m_relock < 255) m_relock++;
                    end
                end else begin
                    m_good++;
                    if (m_good == 16) begin
                        m_good = 0;
                        if (m_bad > 0) m_bad--;
                    end
                end
            end
            if (clr_cnt) begin
                m_err = 0; m_relock = 0;
            end
        end
    endtask

    task automatic tick_w(input logic [9:0] w, input logic ce, input logic re);
        data_win = w; code_err = ce; rd_err = re;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("link_state", 16'(link_state), 16'(m_state));
        check("sync_ok", 16'(sync_ok), 16'(m_state == 2));
        check("sym_tick", 16'(sym_tick), 16'((m_state == 2) && (((cyc - m_align) % 10) == 0)));
        check("rd_load", 16'(rd_load), 16'(m_rdl));
        check("rd_value", 16'(rd_value), 16'(m_rdv));
        check("err_cnt", err_cnt, 16'(m_err));
        check("relock_cnt", 16'(relock_cnt), 16'(m_relock));
    endtask

    task automatic fill(input int n);
        repeat (n) tick_w(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic symbol(input logic [9:0] w, input logic ce, input logic re);
        tick_w(w, ce, re);
        fill(9);
    endtask

    task automatic lock_neg();
        tick_w(K_NEG, 1'b0, 1'b0); fill(9);
        tick_w(K_NEG, 1'b0, 1'b0); fill(9);
        tick_w(K_NEG, 1'b0, 1'b0); fill(9);
    endtask

    initial begin
        int r, n;
        logic [9:0] w;
        resetN = 1'b0; enable = 1'b0; clr_cnt = 1'b0;
        data_win = '0; code_err = 1'b0; rd_err = 1'b0;

        repeat (3) tick_w(rand_word(), 1'b1, 1'b1);
        check("reset_state", 16'(link_state), 16'd0);
        check("reset_sync_ok", 16'(sync_ok), 16'd0);
        check("reset_err_cnt", err_cnt, 16'd0);

        // Acquire lock on RD- commas.
        resetN = 1'b1; enable = 1'b1;
        fill(5);
        tick_w(K_NEG, 1'b0, 1'b0);
        check("hunt_to_verify", 16'(link_state), 16'd1);
        check("rd_load_pulse", 16'(rd_load), 16'd1);
        check("rd_value_neg", 16'(rd_value), 16'd0);
        fill(9); tick_w(K_NEG, 1'b0, 1'b0);
        check("verify_2nd_comma", 16'(link_state), 16'd1);
        fill(9); tick_w(K_NEG, 1'b0, 1'b0);
        check("sync_on_3rd_comma", 16'(link_state), 16'd2);
        fill(9);
        check("sym_tick_boundary", 16'(sym_tick), 16'd1);
        repeat (4) symbol(rand_word(), 1'b0, 1'b0);

        // Four errored symbols (one with both flags) force HUNT.
        symbol(rand_word(), 1'b1, 1'b0);
        symbol(rand_word(), 1'b0, 1'b1);
        symbol(rand_word(), 1'b1, 1'b1);
        check("sync_after_3_errs", 16'(link_state), 16'd2);
        check("err_cnt_3", err_cnt, 16'd3);
        tick_w(rand_word(), 1'b1, 1'b0);
        check("loss_to_hunt", 16'(link_state), 16'd0);
        check("relock_1", 16'(relock_cnt), 16'd1);
        check("err_cnt_4", err_cnt, 16'd4);
        check("sync_ok_falls", 16'(sync_ok), 16'd0);
        fill(9);

        // RD+ comma, then an off-phase comma three bits late re-aligns.
        tick_w(K_POS, 1'b0, 1'b0);
        check("rd_value_pos", 16'(rd_value), 16'd1);
        fill(9); tick_w(rand_word(), 1'b0, 1'b0); fill(2);
        tick_w(K_POS, 1'b0, 1'b0);
        check("realign_pulse", 16'(rd_load), 16'd1);
        fill(9); tick_w(K_POS, 1'b0, 1'b0);
        check("realign_verify", 16'(link_state), 16'd1);
        fill(9); tick_w(K_POS, 1'b0, 1'b0);
        check("realign_sync", 16'(link_state), 16'd2);
        fill(9);

        // Clear, then error forgiveness by a good run.
        clr_cnt = 1'b1; tick_w(rand_word(), 1'b0, 1'b0); clr_cnt = 1'b0;
        check("clr_err_cnt", err_cnt, 16'd0);
        check("clr_relock", 16'(relock_cnt), 16'd0);
        fill(9);
        repeat (3) symbol(rand_word(), 1'b1, 1'b0);
        repeat (16) symbol(rand_word(), 1'b0, 1'b0);
        tick_w(rand_word(), 1'b1, 1'b0);
        check("forgiven_stay_sync", 16'(link_state), 16'd2);
        check("forgiven_err_cnt", err_cnt, 16'd4);
        fill(9);
        tick_w(rand_word(), 1'b0, 1'b1);
        check("bad3_plus1_hunt", 16'(link_state), 16'd0);
        check("relock_after_forgive", 16'(relock_cnt), 16'd1);
        fill(9);

        // Enable low mid-SYNC: HUNT next cycle, counters hold.
        lock_neg();
        symbol(rand_word(), 1'b0, 1'b0);
        enable = 1'b0;
        tick_w(rand_word(), 1'b1, 1'b0);
        check("enable_low_hunt", 16'(link_state), 16'd0);
        check("enable_low_err_hold", err_cnt, 16'd5);
        check("enable_low_relock_hold", 16'(relock_cnt), 16'd1);
        enable = 1'b1;
        fill(4);

        // clr_cnt coincident with an errored symbol.
        lock_neg();
        clr_cnt = 1'b1; tick_w(rand_word(), 1'b1, 1'b0); clr_cnt = 1'b0;
        check("clr_beats_inc", err_cnt, 16'd0);
        check("clr_keeps_state", 16'(link_state), 16'd2);
        fill(9);

        // VERIFY with no further comma for 64 symbols.
        enable = 1'b0; tick_w(rand_word(), 1'b0, 1'b0); enable = 1'b1;
        tick_w(K_NEG, 1'b0, 1'b0); fill(9);
        repeat (63) symbol(rand_word(), 1'b0, 1'b0);
        check("verify_63_symbols", 16'(link_state), 16'd1);
        tick_w(rand_word(), 1'b0, 1'b0);
`ifdef RX_ALIGN_TIMEOUT_EN
        check("verify_timeout_hunt", 16'(link_state), 16'd0);
`else
        check("verify_no_timeout", 16'(link_state), 16'd1);
`endif
        check("timeout_relock_hold", 16'(relock_cnt), 16'd0);
        fill(9);

        // Randomized symbol streams with jittered spacing, errors, clears, enable drops and resets.
        for (int i = 0; i < 500; i++) begin
            resetN  = ($urandom_range(0, 199) != 0);
            enable  = ($urandom_range(0, 49) != 0);
            clr_cnt = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 99);
            w = (r < 30) ? K_NEG : ((r < 55) ? K_POS : rand_word());
            tick_w(w, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5));
            resetN = 1'b1; enable = 1'b1; clr_cnt = 1'b0;
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 14) : 9;
            fill(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
